// File: rtl/decodifica_movimentos.sv
// Parses ASCII cube moves ("R U' F2#") from the serial byte stream into a FIFO of 5-bit moves; 1 clock from byte strobe to mov_valido.
// Consumer pops with mov_valido & mov_aceito; pushing into a full FIFO without a same-cycle pop drops the move and enters ERRO.

module fifo_movs #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int W      = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [W-1:0]      push_dat,
    input  logic              pop,
    output logic [W-1:0]      head_dat,
    output logic              head_vld,
    output logic              full,
    output logic [ADDR_W:0]   count
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [W-1:0]      mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic              pop_en;
    logic              wr_en;

    assign head_vld = (cnt != '0);
    assign full     = (cnt == FULL_CNT);
    assign count    = cnt;
    assign pop_en   = pop & head_vld;
    // A pop frees the slot in the same edge, so a full FIFO still accepts the push.
    assign wr_en    = push & (~full | pop_en);
    assign head_dat = head_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en && !flush && !reset)
            mem[wr_ptr] <= push_dat;
    end
endmodule

module decodifica_movimentos #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        dados_rx,
    input  logic              pronto_rx,
    input  logic              limpa,
    input  logic              mov_aceito,
    output logic [4:0]        movimento,
    output logic              mov_valido,
    output logic [ADDR_W:0]   num_movs,
    output logic              fim_seq,
    output logic              erro,
    output logic [3:0]        db_estado
);
    typedef enum logic [3:0] {
        OCIOSO    = 4'h0,
        FACE_PEND = 4'h1,
        ERRO      = 4'hE
    } estado_t;

    estado_t     estado, estado_n;
    logic [2:0]  face_q, face_n;
    logic        fim_q, fim_n;

    logic        is_face;
    logic [2:0]  face_code;
    logic        is_ccw;
    logic        is_dbl;
    logic        is_hash;
    logic        is_ign;
    logic        byte_vld;

    logic        push;
    logic [4:0]  push_dat;
    logic        fifo_full;
    logic        overflow;

    always_comb begin
        is_face   = 1'b1;
        face_code = 3'd0;
        case (dados_rx)
            8'h55:   face_code = 3'd0;
            8'h44:   face_code = 3'd1;
            8'h4C:   face_code = 3'd2;
            8'h52:   face_code = 3'd3;
            8'h46:   face_code = 3'd4;
            8'h42:   face_code = 3'd5;
            default: is_face   = 1'b0;
        endcase
    end

    assign is_ccw  = (dados_rx == 8'h27);
    assign is_dbl  = (dados_rx == 8'h32);
    assign is_hash = (dados_rx == 8'h23);
    assign is_ign  = (dados_rx == 8'h20) || (dados_rx == 8'h0D) || (dados_rx == 8'h0A);
    // Whitespace is invisible to the parser, so "R '" still means R'.
    assign byte_vld = pronto_rx & ~is_ign & ~limpa;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= OCIOSO;
            face_q <= 3'd0;
            fim_q  <= 1'b0;
        end else begin
            estado <= estado_n;
            face_q <= face_n;
            fim_q  <= fim_n;
        end
    end

    always_comb begin
        estado_n = estado;
        face_n   = face_q;
        fim_n    = fim_q;
        if (limpa) begin
            estado_n = OCIOSO;
            face_n   = 3'd0;
            fim_n    = 1'b0;
        end else if (byte_vld) begin
            case (estado)
                OCIOSO: begin
                    if (is_face) begin
                        face_n   = face_code;
                        estado_n = FACE_PEND;
                        fim_n    = 1'b0;
                    end else if (is_hash) begin
                        fim_n    = 1'b1;
                    end else begin
                        estado_n = ERRO;
                        fim_n    = 1'b0;
                    end
                end
                FACE_PEND: begin
                    if (is_ccw || is_dbl) begin
                        estado_n = OCIOSO;
                    end else if (is_face) begin
                        face_n   = face_code;
                    end else if (is_hash) begin
                        estado_n = OCIOSO;
                        fim_n    = 1'b1;
                    end else begin
                        estado_n = ERRO;
                        fim_n    = 1'b0;
                    end
                end
                ERRO: begin
                    if (is_hash)
                        estado_n = OCIOSO;
                end
                default: estado_n = OCIOSO;
            endcase
            // A dropped move invalidates the sequence: no end-of-sequence flag either.
            if (overflow) begin
                estado_n = ERRO;
                fim_n    = 1'b0;
            end
        end
    end

    always_comb begin
        push     = 1'b0;
        push_dat = {face_q, 2'b01};
        if (byte_vld && estado == FACE_PEND) begin
            if (is_ccw) begin
                push     = 1'b1;
                push_dat = {face_q, 2'b10};
            end else if (is_dbl) begin
                push     = 1'b1;
                push_dat = {face_q, 2'b11};
            end else if (is_face || is_hash) begin
                push     = 1'b1;
            end
        end
        overflow  = push & fifo_full & ~mov_aceito;
        erro      = (estado == ERRO);
        db_estado = estado;
        fim_seq   = fim_q;
    end

    fifo_movs #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .W      (5)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (limpa),
        .push     (push),
        .push_dat (push_dat),
        .pop      (mov_aceito),
        .head_dat (movimento),
        .head_vld (mov_valido),
        .full     (fifo_full),
        .count    (num_movs)
    );
endmodule
